pipe_hazard_ctrl: RTL and testbench

//  Parametrised hazard/forwarding controller for the pipelined RV32 core. Keeps a shift-register

---
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Hazard / forwarding controller for the pipelined RV32 core.
//                Tracks the instructions downstream of ID in a shift-register
//                scoreboard (slot 0 = EX) and derives operand forward
//                selects, load-use stall/bubble, branch flushes and
//                saturating stall/flush event counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int RA_W      = 5,   // register-index width
    parameter int DEPTH     = 3,   // tracked slots after ID, 1..7 (3-bit fwd code)
    parameter int LOAD_SLOT = 1,   // first slot whose load data is forwardable
    parameter int CNT_W     = 32   // event counter width
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic             id_rs1_use_i,
    input  logic             id_rs2_use_i,
    input  logic [RA_W-1:0]  id_rd_i,
    input  logic             id_we_i,
    input  logic             id_load_i,
    input  logic             br_taken_i,
    output logic             stall_o,
    output logic             bubble_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic [2:0]       fwd_a_o,
    output logic [2:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Scoreboard storage: one entry per downstream stage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]           slot_v;
    logic [DEPTH-1:0]           slot_we;
    logic [DEPTH-1:0]           slot_ld;
    logic [DEPTH-1:0][RA_W-1:0] slot_rd;

    // Per-slot derived flags
    logic [DEPTH-1:0] producer;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;

    // Operand resolution results
    logic       hit_a;
    logic       hit_b;
    logic       rdy_a;
    logic       rdy_b;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic       haz_a;
    logic       haz_b;
    logic       hazard;
    logic       issue;

    // ------------------------------------------------------------------
    // Per-slot producer / readiness / operand-match flags.
    // x0 never produces, so a read of x0 can never match.
    // A load's data exists only once it has reached LOAD_SLOT; readiness
    // per slot is therefore a constant mask ANDed with the load flag.
    // ------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_slot
            localparam bit LOAD_OK = (g >= LOAD_SLOT);

            assign producer[g] = slot_v[g] & slot_we[g] & (slot_rd[g] != '0);
            assign ready[g]    = ~slot_ld[g] | LOAD_OK;
            assign match_a[g]  = id_valid_i & id_rs1_use_i & producer[g]
                               & (slot_rd[g] == id_rs1_i);
            assign match_b[g]  = id_valid_i & id_rs2_use_i & producer[g]
                               & (slot_rd[g] == id_rs2_i);
        end
    endgenerate

    // Youngest-match priority select: scan oldest to youngest so the lowest
    // matching slot is the last one written and wins.
    always_comb begin
        hit_a = 1'b0;
        rdy_a = 1'b0;
        sel_a = 3'd0;
        hit_b = 1'b0;
        rdy_b = 1'b0;
        sel_b = 3'd0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match_a[i]) begin
                hit_a = 1'b1;
                rdy_a = ready[i];
                sel_a = 3'(i + 1);
            end
            if (match_b[i]) begin
                hit_b = 1'b1;
                rdy_b = ready[i];
                sel_b = 3'(i + 1);
            end
        end
    end

    // A hazard exists when an operand's youngest producer cannot supply
    // its data yet; both operands hitting still yields a single stall.
    assign haz_a  = hit_a & ~rdy_a;
    assign haz_b  = hit_b & ~rdy_b;
    assign hazard = haz_a | haz_b;

    // ------------------------------------------------------------------
    // Pipeline controls. A taken branch kills the younger instructions, so
    // stalling them would be pointless: flush has priority over stall.
    // Outputs are forced low while reset is asserted.
    // ------------------------------------------------------------------
    assign flush_ifid_o = ~rst_i & br_taken_i;
    assign flush_idex_o = ~rst_i & br_taken_i;
    assign stall_o      = ~rst_i & ~br_taken_i & hazard;
    assign bubble_o     = ~rst_i & ~br_taken_i & hazard;
    assign fwd_a_o      = (~rst_i & hit_a & rdy_a) ? sel_a : 3'd0;
    assign fwd_b_o      = (~rst_i & hit_b & rdy_b) ? sel_b : 3'd0;

    // The ID instruction enters EX only when it is neither held nor killed.
    assign issue = id_valid_i & ~stall_o & ~br_taken_i;

    // Scoreboard shift: every edge entries age by one slot and the oldest
    // drops out; slot 0 takes the issuing instruction or an invalid bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_v  <= '0;
            slot_we <= '0;
            slot_ld <= '0;
            slot_rd <= '0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                slot_v[i]  <= slot_v[i-1];
                slot_we[i] <= slot_we[i-1];
                slot_ld[i] <= slot_ld[i-1];
                slot_rd[i] <= slot_rd[i-1];
            end
            slot_v[0]  <= issue;
            slot_we[0] <= id_we_i;
            slot_ld[0] <= id_load_i;
            slot_rd[0] <= id_rd_i;
        end
    end

    // Saturating stall-cycle counter: sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_ONE;
        end
    end

    // Saturating taken-branch (flush) cycle counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flush_cnt_o <= '0;
        end else if (br_taken_i && (flush_cnt_o != CNT_MAX)) begin
            flush_cnt_o <= flush_cnt_o + CNT_ONE;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//                plus randomized traffic against a queue-based model of the
//                instructions in flight. A second instance with 2-bit
//                counters exercises counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int RA_W      = 5;
    localparam int DEPTH     = 3;
    localparam int LOAD_SLOT = 1;
    localparam int CNT_W     = 32;
    localparam int SAT_W     = 2;
    localparam int SAT_MAX   = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs1_use;
    logic            id_rs2_use;
    logic [RA_W-1:0] id_rd;
    logic            id_we;
    logic            id_load;
    logic            br_taken;

    logic             stall_o;
    logic             bubble_o;
    logic             flush_ifid_o;
    logic             flush_idex_o;
    logic [2:0]       fwd_a_o;
    logic [2:0]       fwd_b_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    logic             s_stall;
    logic             s_bubble;
    logic             s_flush_ifid;
    logic             s_flush_idex;
    logic [2:0]       s_fwd_a;
    logic [2:0]       s_fwd_b;
    logic [SAT_W-1:0] s_stall_cnt;
    logic [SAT_W-1:0] s_flush_cnt;

    int checks = 0;
    int errors = 0;

    // Model of instructions in flight: index 0 is the youngest (EX).
    typedef struct {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            ld;
    } ent_t;
    ent_t pipe_q[$];
    int   m_stall_cnt;
    int   m_flush_cnt;

    pipe_hazard_ctrl #(
        .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load),
        .br_taken_i(br_taken),
        .stall_o(stall_o), .bubble_o(bubble_o),
        .flush_ifid_o(flush_ifid_o), .flush_idex_o(flush_idex_o),
        .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_hazard_ctrl #(
        .RA_W(RA_W), .DEPTH(DEPTH), .LOAD_SLOT(LOAD_SLOT), .CNT_W(SAT_W)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
        .id_rd_i(id_rd), .id_we_i(id_we), .id_load_i(id_load),
        .br_taken_i(br_taken),
        .stall_o(s_stall), .bubble_o(s_bubble),
        .flush_ifid_o(s_flush_ifid), .flush_idex_o(s_flush_idex),
        .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [RA_W-1:0] rs1, input logic u1,
                         input logic [RA_W-1:0] rs2, input logic u2,
                         input logic [RA_W-1:0] rd, input logic we, input logic ld,
                         input logic br);
        id_valid   = v;
        id_rs1     = rs1;
        id_rs1_use = u1;
        id_rs2     = rs2;
        id_rs2_use = u2;
        id_rd      = rd;
        id_we      = we;
        id_load    = ld;
        br_taken   = br;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        pipe_q.delete();
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Youngest producer of rs: returns {not_ready, fwd_code}.
    function automatic logic [3:0] ref_src(input logic [RA_W-1:0] rs, input logic used);
        if (!id_valid || !used) return 4'd0;
        foreach (pipe_q[k]) begin
            if (pipe_q[k].v && pipe_q[k].we && pipe_q[k].rd != 0 && pipe_q[k].rd == rs) begin
                if (pipe_q[k].ld && k < LOAD_SLOT) return 4'b1000;
                return {1'b0, 3'(k + 1)};
            end
        end
        return 4'd0;
    endfunction

    task automatic test_reset();
        // Active inputs during reset, including a branch: outputs must still be 0.
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if ({stall_o, bubble_o, flush_ifid_o, flush_idex_o, fwd_a_o, fwd_b_o} !== 10'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0",
                     {stall_o, bubble_o, flush_ifid_o, flush_idex_o, fwd_a_o, fwd_b_o});
        end
        checks++;
        if (stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o);
        end
        apply_reset();
    endtask

    task automatic test_alu_forward();
        apply_reset();
        drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);   // add x5,x1,x2
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);   // sub x6,x5,x1
        #1;
        checks++;
        if (fwd_a_o !== 3'd1 || fwd_b_o !== 3'd0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL alu_fwd got a=%0d b=%0d st=%b want a=1 b=0 st=0",
                     fwd_a_o, fwd_b_o, stall_o);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);   // add x7,x5,x5
        #1;
        checks++;
        if (stall_o !== 1'b1 || bubble_o !== 1'b1 || fwd_a_o !== 3'd0) begin
            errors++;
            $display("FAIL ld_use_stall got st=%b bub=%b a=%0d want 1 1 0",
                     stall_o, bubble_o, fwd_a_o);
        end
        tick();
        checks++;
        if (stall_o !== 1'b0 || fwd_a_o !== 3'd2 || fwd_b_o !== 3'd2) begin
            errors++;
            $display("FAIL ld_use_fwd got st=%b a=%0d b=%0d want 0 2 2",
                     stall_o, fwd_a_o, fwd_b_o);
        end
        checks++;
        if (stall_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL ld_use_cnt got %0d want 1", stall_cnt_o);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);   // addi x0,x0,1
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fwd_a_o !== 3'd0 || fwd_b_o !== 3'd0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL x0_nofwd got a=%0d b=%0d st=%b want 0 0 0", fwd_a_o, fwd_b_o, stall_o);
        end
    endtask

    task automatic test_youngest();
        apply_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fwd_a_o !== 3'd1 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL youngest got a=%0d st=%b want 1 0", fwd_a_o, stall_o);
        end
        // Youngest writer is now a load in EX with an older ALU writer behind it.
        apply_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fwd_b_o !== 3'd0 || stall_o !== 1'b1) begin
            errors++;
            $display("FAIL youngest_ld got b=%0d st=%b want 0 1", fwd_b_o, stall_o);
        end
    endtask

    task automatic test_branch_flush();
        apply_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);   // add x9,x5 + branch
        #1;
        checks++;
        if ({flush_ifid_o, flush_idex_o, stall_o, bubble_o} !== 4'b1100) begin
            errors++;
            $display("FAIL br_flush got %b want 1100",
                     {flush_ifid_o, flush_idex_o, stall_o, bubble_o});
        end
        tick();
        checks++;
        if (flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL br_cnt got fl=%0d st=%0d want 1 0", flush_cnt_o, stall_cnt_o);
        end
        // Flushed add must not sit in EX: x9 unforwarded, x5 from the load at slot 1.
        drive(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fwd_a_o !== 3'd0 || fwd_b_o !== 3'd2 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL br_bubble got a=%0d b=%0d st=%b want 0 2 0", fwd_a_o, fwd_b_o, stall_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);   // lw x5
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);   // use x5, stalls once
        tick();
        tick();                                                        // add issues
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);   // lw x6
        tick();
        drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);   // use x6
        #1;
        checks++;
        if (stall_o !== 1'b1 || stall_cnt_o !== 32'd1) begin
            errors++;
            $display("FAIL rst_pre got st=%b cnt=%0d want 1 1", stall_o, stall_cnt_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (stall_o !== 1'b0 || stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            errors++;
            $display("FAIL rst_async got st=%b cnt=%0d/%0d want 0 0/0",
                     stall_o, stall_cnt_o, flush_cnt_o);
        end
        rst = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fwd_a_o !== 3'd0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_post got a=%0d st=%b want 0 0", fwd_a_o, stall_o);
        end
        pipe_q.delete();
    endtask

    task automatic test_random();
        logic [3:0] ra;
        logic [3:0] rb;
        logic       e_stall;
        logic       v, u1, u2, we, ld, br;
        logic [RA_W-1:0] rs1, rs2, rd;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 7) != 0);
            rs1 = RA_W'($urandom_range(0, 3));
            rs2 = RA_W'($urandom_range(0, 3));
            u1  = ($urandom_range(0, 3) != 0);
            u2  = ($urandom_range(0, 1) != 0);
            rd  = RA_W'($urandom_range(0, 3));
            we  = ($urandom_range(0, 4) != 0);
            ld  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 7) == 0);
            drive(v, rs1, u1, rs2, u2, rd, we, ld, br);
            #1;
            ra      = ref_src(rs1, u1);
            rb      = ref_src(rs2, u2);
            e_stall = !br && (ra[3] || rb[3]);
            checks++;
            if (fwd_a_o !== ra[2:0] || fwd_b_o !== rb[2:0]) begin
                errors++;
                $display("FAIL rnd_fwd n=%0d got a=%0d b=%0d want a=%0d b=%0d",
                         n, fwd_a_o, fwd_b_o, ra[2:0], rb[2:0]);
            end
            checks++;
            if ({stall_o, bubble_o, flush_ifid_o, flush_idex_o} !== {e_stall, e_stall, br, br}) begin
                errors++;
                $display("FAIL rnd_ctrl n=%0d got %b want %b", n,
                         {stall_o, bubble_o, flush_ifid_o, flush_idex_o},
                         {e_stall, e_stall, br, br});
            end
            checks++;
            if ({s_stall, s_bubble, s_flush_ifid, s_flush_idex, s_fwd_a, s_fwd_b} !==
                {e_stall, e_stall, br, br, ra[2:0], rb[2:0]}) begin
                errors++;
                $display("FAIL rnd_sat_ctrl n=%0d got %b", n,
                         {s_stall, s_bubble, s_flush_ifid, s_flush_idex, s_fwd_a, s_fwd_b});
            end
            checks++;
            if (stall_cnt_o !== CNT_W'(m_stall_cnt) || flush_cnt_o !== CNT_W'(m_flush_cnt)) begin
                errors++;
                $display("FAIL rnd_cnt n=%0d got %0d/%0d want %0d/%0d", n,
                         stall_cnt_o, flush_cnt_o, m_stall_cnt, m_flush_cnt);
            end
            checks++;
            if (s_stall_cnt !== SAT_W'((m_stall_cnt > SAT_MAX) ? SAT_MAX : m_stall_cnt) ||
                s_flush_cnt !== SAT_W'((m_flush_cnt > SAT_MAX) ? SAT_MAX : m_flush_cnt)) begin
                errors++;
                $display("FAIL rnd_sat_cnt n=%0d got %0d/%0d want min(%0d,3)/min(%0d,3)", n,
                         s_stall_cnt, s_flush_cnt, m_stall_cnt, m_flush_cnt);
            end
            tick();
            pipe_q.push_front(ent_t'{v && !e_stall && !br, rd, we, ld});
            if (pipe_q.size() > DEPTH) pipe_q.delete(DEPTH);
            if (e_stall) m_stall_cnt++;
            if (br) m_flush_cnt++;
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_x0();
        test_youngest();
        test_branch_flush();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
